// File: rtl/chan_cfg_pkg.sv
// Shared types and length rules for the channelizer configuration sequencer.
package chan_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_TAPS,
    ST_MASK,
    ST_FLUSH,
    ST_RUN
  } cfg_state_e;

  localparam int unsigned MASK_BITS_PER_WORD = 32;

  // Word count a config block must have in the given state; 1 elsewhere keeps compares sane.
  function automatic int unsigned exp_len(cfg_state_e st, int unsigned m, int unsigned taps);
    case (st)
      ST_TAPS: return m * taps;
      ST_MASK: return m / MASK_BITS_PER_WORD;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/axis_route1to2.sv
// Zero-latency AXI-stream demux: one source steered to one of two sinks, or swallowed when drop is set.
module axis_route1to2 #(
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              en,
  input  logic              drop,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m0_tvalid,
  input  logic              m0_tready,
  output logic [DATA_W-1:0] m0_tdata,
  output logic              m0_tlast,
  output logic              m1_tvalid,
  input  logic              m1_tready,
  output logic [DATA_W-1:0] m1_tdata,
  output logic              m1_tlast
);

  assign m0_tvalid = s_tvalid & en & ~drop & ~sel;
  assign m1_tvalid = s_tvalid & en & ~drop & sel;
  assign m0_tdata  = s_tdata;
  assign m1_tdata  = s_tdata;
  assign m0_tlast  = s_tlast;
  assign m1_tlast  = s_tlast;

  // tvalid never looks at tready; only the backward path is muxed.
  assign s_tready = drop | (en & (sel ? m1_tready : m0_tready));

endmodule

// File: rtl/chan_cfg_sequencer.sv
// Steers host config into channelizer tap-reload then bin-select ports, gating samples to FFT-block boundaries.
//
// state | meaning
// IDLE  | no config, samples gated; start_i begins a config
// HALT  | samples still pass until the current FFT block completes
// TAPS  | cfg stream routed to tap reload port
// MASK  | cfg stream routed to bin select port
// FLUSH | overlong block: cfg words discarded up to tlast
// RUN   | samples pass through; start_i requests reconfiguration
module chan_cfg_sequencer
  import chan_cfg_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          FFT_SIZE_WIDTH = 12,
  parameter int unsigned TAPS_PER_PHASE = 32,
  parameter int          CNT_W          = 17
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  input  logic                      start_i,
  input  logic                      s_axis_cfg_tvalid,
  output logic                      s_axis_cfg_tready,
  input  logic [DATA_W-1:0]         s_axis_cfg_tdata,
  input  logic                      s_axis_cfg_tlast,
  output logic                      m_axis_reload_tvalid,
  input  logic                      m_axis_reload_tready,
  output logic [DATA_W-1:0]         m_axis_reload_tdata,
  output logic                      m_axis_reload_tlast,
  output logic                      m_axis_select_tvalid,
  input  logic                      m_axis_select_tready,
  output logic [DATA_W-1:0]         m_axis_select_tdata,
  output logic                      m_axis_select_tlast,
  input  logic                      s_axis_data_tvalid,
  output logic                      s_axis_data_tready,
  input  logic [DATA_W-1:0]         s_axis_data_tdata,
  output logic                      m_axis_data_tvalid,
  input  logic                      m_axis_data_tready,
  output logic [DATA_W-1:0]         m_axis_data_tdata,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  localparam int SCW = FFT_SIZE_WIDTH - 1;

  cfg_state_e                state;
  logic [FFT_SIZE_WIDTH-1:0] m_reg;
  logic [FFT_SIZE_WIDTH-1:0] m_pend;
  logic [SCW-1:0]            sample_cnt;
  logic [CNT_W-1:0]          word_cnt;
  logic [CNT_W-1:0]          exp_m1;
  logic                      pass;
  logic                      data_hs;
  logic                      cfg_hs;
  logic                      at_last;
  logic                      sample_wrap;
  logic                      route_en;
  logic                      route_sel;
  logic                      route_drop;

  // HALT stops passing the moment the block boundary is reached.
  assign pass = (state == ST_RUN) || ((state == ST_HALT) && (sample_cnt != '0));

  assign m_axis_data_tvalid = pass & s_axis_data_tvalid;
  assign s_axis_data_tready = pass & m_axis_data_tready;
  assign m_axis_data_tdata  = s_axis_data_tdata;
  assign data_hs            = m_axis_data_tvalid & m_axis_data_tready;

  assign route_en   = (state == ST_TAPS) || (state == ST_MASK);
  assign route_sel  = (state == ST_MASK);
  assign route_drop = (state == ST_FLUSH);

  axis_route1to2 #(.DATA_W(DATA_W)) u_route (
    .sel       (route_sel),
    .en        (route_en),
    .drop      (route_drop),
    .s_tvalid  (s_axis_cfg_tvalid),
    .s_tready  (s_axis_cfg_tready),
    .s_tdata   (s_axis_cfg_tdata),
    .s_tlast   (s_axis_cfg_tlast),
    .m0_tvalid (m_axis_reload_tvalid),
    .m0_tready (m_axis_reload_tready),
    .m0_tdata  (m_axis_reload_tdata),
    .m0_tlast  (m_axis_reload_tlast),
    .m1_tvalid (m_axis_select_tvalid),
    .m1_tready (m_axis_select_tready),
    .m1_tdata  (m_axis_select_tdata),
    .m1_tlast  (m_axis_select_tlast)
  );

  assign cfg_hs      = s_axis_cfg_tvalid & s_axis_cfg_tready;
  assign exp_m1      = CNT_W'(exp_len(state, 32'(m_reg), TAPS_PER_PHASE) - 32'd1);
  assign at_last     = (word_cnt == exp_m1);
  assign sample_wrap = ({1'b0, sample_cnt} == (m_reg - 1'b1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      m_reg      <= '0;
      m_pend     <= '0;
      sample_cnt <= '0;
      word_cnt   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (data_hs) sample_cnt <= sample_wrap ? '0 : sample_cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            m_reg      <= fft_size;
            err_o      <= 1'b0;
            word_cnt   <= '0;
            sample_cnt <= '0;
            busy_o     <= 1'b1;
            state      <= ST_TAPS;
          end
        end
        ST_RUN: begin
          if (start_i) begin
            err_o  <= 1'b0;
            busy_o <= 1'b1;
            m_pend <= fft_size;
            // Already on a boundary with nothing moving: no drain needed.
            if ((sample_cnt == '0) && !data_hs) begin
              m_reg <= fft_size;
              state <= ST_TAPS;
            end else begin
              state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          if (sample_cnt == '0) begin
            m_reg <= m_pend;
            state <= ST_TAPS;
          end
        end
        ST_TAPS, ST_MASK: begin
          if (cfg_hs) begin
            if (s_axis_cfg_tlast && at_last) begin
              word_cnt   <= '0;
              sample_cnt <= '0;
              if (state == ST_TAPS) begin
                state <= ST_MASK;
              end else begin
                state  <= ST_RUN;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end
            end else if (s_axis_cfg_tlast) begin
              err_o    <= 1'b1;
              word_cnt <= '0;
              busy_o   <= 1'b0;
              state    <= ST_IDLE;
            end else if (at_last) begin
              err_o    <= 1'b1;
              word_cnt <= '0;
              state    <= ST_FLUSH;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (cfg_hs && s_axis_cfg_tlast) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_cfg_sequencer.sv
// Randomized bench for chan_cfg_sequencer: host-level model predicts per-port word counts, sums and drain points.
module tb_chan_cfg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] fft_size;
  logic        start_i;
  logic        cv, cr, cl;
  logic [31:0] cd;
  logic        rlv, rlr, rll, slv, slr, sll;
  logic [31:0] rld, sld;
  logic        sdv, sdr, mdv, mdr;
  logic [31:0] sdd, mdd;
  logic        busy, done, err;

  chan_cfg_sequencer dut (
    .clk(clk), .reset_n(reset_n), .fft_size(fft_size), .start_i(start_i),
    .s_axis_cfg_tvalid(cv), .s_axis_cfg_tready(cr), .s_axis_cfg_tdata(cd), .s_axis_cfg_tlast(cl),
    .m_axis_reload_tvalid(rlv), .m_axis_reload_tready(rlr), .m_axis_reload_tdata(rld), .m_axis_reload_tlast(rll),
    .m_axis_select_tvalid(slv), .m_axis_select_tready(slr), .m_axis_select_tdata(sld), .m_axis_select_tlast(sll),
    .s_axis_data_tvalid(sdv), .s_axis_data_tready(sdr), .s_axis_data_tdata(sdd),
    .m_axis_data_tvalid(mdv), .m_axis_data_tready(mdr), .m_axis_data_tdata(mdd),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;
  bit thr = 0, src_en = 1, stuck = 0;
  int rl_n, sl_n, rl_last, sl_last, sl_vis, done_n, leak, dat_bad;
  logic [31:0] rl_sum, sl_sum;
  int dat_cnt = 0, dat_at_rl = 0, dat_at_start = 0, run_base = 0, prev_m = 0;
  bit rl_seen, in_cfg;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int n);
    return 32'(n) * 32'h9E3779B1 + 32'd7;
  endfunction

  // Downstream readies and upstream sample source, driven just after the active edge.
  initial begin
    rlr = 1'b1; slr = 1'b1; mdr = 1'b1; sdv = 1'b1; sdd = pat(0);
    forever begin
      @(posedge clk); #1;
      rlr = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      slr = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      mdr = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
      sdv = src_en && (thr ? ($urandom_range(0, 3) != 0) : 1'b1);
      sdd = pat(dat_cnt);
    end
  end

  // Monitor: values at negedge are what the next posedge will act on.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin done_n++; run_base = dat_cnt; in_cfg = 0; end
      if (slv) sl_vis++;
      if (rlv && rlr) begin
        if (!rl_seen) begin rl_seen = 1; dat_at_rl = dat_cnt; in_cfg = 1; end
        rl_n++; rl_sum += rld;
        if (rll) rl_last++;
      end
      if (slv && slr) begin
        sl_n++; sl_sum += sld;
        if (sll) sl_last++;
      end
      if (mdv && mdr) begin
        if (in_cfg) leak++;
        if (mdd !== pat(dat_cnt)) dat_bad++;
        dat_cnt++;
      end
      if (start_i) dat_at_start = dat_cnt;
    end
  end

  task automatic push_word(input logic [31:0] d, input logic l);
    int guard;
    if (stuck) return;
    if (thr) while ($urandom_range(0, 2) == 0) begin cv = 1'b0; @(posedge clk); #1; end
    cv = 1'b1; cd = d; cl = l; guard = 0;
    @(negedge clk);
    while (!cr && guard < 5000) begin @(negedge clk); guard++; end
    if (!cr) begin chk_val("cfg_wait", 32'd0, 32'd1); stuck = 1; end
    @(posedge clk); #1;
    cv = 1'b0; cl = 1'b0;
  endtask

  task automatic pulse_start(input int m);
    @(posedge clk); #1;
    fft_size = 12'(m); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // One host transaction: taps block of t words, then (if taps was right) mask block of k words; tlast on each block's last word.
  task automatic run_scenario(input int m, input int t, input int k, input int pre);
    int et, ek, rl_e, sl_e, prev_base, exp_rl, rel;
    bit ok_e, rl_last_e, sl_last_e;
    logic [31:0] tw[$];
    logic [31:0] mw[$];
    logic [31:0] rs, ss;
    et = m * 32; ek = m / 32;
    for (int i = 0; i < t; i++) tw.push_back($urandom);
    for (int i = 0; i < k; i++) mw.push_back($urandom);
    ok_e      = (t == et) && (k == ek);
    rl_e      = (t < et) ? t : et;
    rl_last_e = (t <= et);
    sl_e      = (t == et) ? ((k < ek) ? k : ek) : 0;
    sl_last_e = (t == et) && (k <= ek);
    rs = 0; ss = 0;
    for (int i = 0; i < rl_e; i++) rs += tw[i];
    for (int i = 0; i < sl_e; i++) ss += mw[i];

    rl_n = 0; sl_n = 0; rl_last = 0; sl_last = 0; sl_vis = 0; done_n = 0; leak = 0;
    dat_bad = 0; rl_sum = 0; sl_sum = 0; rl_seen = 0; in_cfg = 0;
    repeat (pre) @(posedge clk);
    prev_base = run_base;
    pulse_start(m);
    chk_val("busy_cfg", 32'(busy), 32'd1);
    for (int i = 0; i < t; i++) push_word(tw[i], i == t - 1);
    if (t == et) for (int i = 0; i < k; i++) push_word(mw[i], i == k - 1);
    repeat (40) @(posedge clk);
    #1;

    // From RUN the old block must finish first: gating lands on the next multiple of the old M.
    rel    = dat_at_start - prev_base;
    exp_rl = (prev_m != 0) ? prev_base + ((rel + prev_m - 1) / prev_m) * prev_m : dat_at_start;

    chk_val("rl_words", rl_n, rl_e);
    chk_val("rl_sum", rl_sum, rs);
    chk_val("rl_tlast", rl_last, 32'(rl_last_e));
    chk_val("sl_words", sl_n, sl_e);
    chk_val("sl_sum", sl_sum, ss);
    chk_val("sl_tlast", sl_last, 32'(sl_last_e));
    if (t != et) chk_val("sl_idle", sl_vis, 0);
    chk_val("err", 32'(err), 32'(!ok_e));
    chk_val("done_pulses", done_n, 32'(ok_e));
    chk_val("busy_end", 32'(busy), 32'd0);
    chk_val("cfg_leak", leak, 0);
    chk_val("data_bad", dat_bad, 0);
    chk_val("drain_point", dat_at_rl, exp_rl);
    if (ok_e) chk_val("data_flows", 32'(dat_cnt > dat_at_rl), 32'd1);
    else      chk_val("data_gated", dat_cnt, dat_at_rl);
    prev_m = ok_e ? m : 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start_i = 1'b0; fft_size = '0;
    cv = 1'b1; cd = 32'hA5A5_0001; cl = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_outs", 32'({rlv, slv, mdv, cr, sdr, busy, done, err}), 32'd0);
    cv = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;

    run_scenario(2048, 65536, 64, 0);   // largest M: 17-bit word count
    run_scenario(32, 1024, 1, 300);     // restart mid-block of M=2048: drain to 2048
    run_scenario(32, 100, 0, 0);        // taps tlast too early
    run_scenario(64, 2048, 3, 0);       // mask one word too long -> flush

    // Reset while taps are streaming.
    pulse_start(32);
    for (int i = 0; i < 100; i++) push_word($urandom, 1'b0);
    cv = 1'b1; cd = 32'h1234_5678; cl = 1'b0;
    #1;
    chk_val("pre_rst_valid", 32'({rlv, busy}), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    chk_val("rst_outs_async", 32'({rlv, slv, mdv, cr, sdr, busy, done, err}), 32'd0);
    cv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1; prev_m = 0;
    run_scenario(32, 1024, 1, 0);

    thr = 1;
    for (int it = 0; it < 3; it++) begin
      int t, k, v;
      v = (it == 0) ? 0 : int'($urandom_range(0, 2));
      t = (v == 0) ? 1024 : (v == 1) ? int'($urandom_range(1, 1023)) : 1024 + int'($urandom_range(1, 3));
      k = (it == 0 || $urandom_range(0, 1) == 0) ? 1 : 1 + int'($urandom_range(1, 3));
      run_scenario(32, t, k, int'($urandom_range(0, 50)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/chan_cfg_sequencer.md
# chan_cfg_sequencer

Configuration sequencer for the M-path polyphase channelizer. It takes one host configuration stream and steers it into the channelizer's tap-reload port, then into its bin-select mask port, in a fixed order. It gates the input sample stream so that reconfiguration only ever starts on an FFT-block boundary. The block sits between the host/DMA side and the channelizer top, and owns the channelizer's reload, select and data-input handshakes.

## Interface
- DATA_W, 32, width of config and sample words
- FFT_SIZE_WIDTH, 12, width of fft_size
- TAPS_PER_PHASE, 32, taps per polyphase branch
- CNT_W, 17, word counter width; must hold 2^(FFT_SIZE_WIDTH-1)*TAPS_PER_PHASE
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- fft_size  in  FFT_SIZE_WIDTH  channel count M, a power of two from 32 to 2048; sampled at start_i
- start_i  in  1  one-cycle reconfiguration request
- s_axis_cfg_tvalid/tready/tdata[DATA_W]/tlast  in/out  host config stream: taps block, then mask block, each ending in tlast
- m_axis_reload_tvalid/tready/tdata[DATA_W]/tlast  out/in  to channelizer tap reload
- m_axis_select_tvalid/tready/tdata[DATA_W]/tlast  out/in  to channelizer bin select
- s_axis_data_tvalid/tready/tdata[DATA_W]  in/out  sample stream from upstream
- m_axis_data_tvalid/tready/tdata[DATA_W]  out/in  sample stream to channelizer
- busy_o  out  1  high in every state except RUN and IDLE
- done_o  out  1  one-cycle pulse when RUN is entered
- err_o  out  1  sticky length error; cleared only by start_i or reset

## Operation
- States: IDLE, HALT, TAPS, MASK, FLUSH, RUN.
- IDLE (reset state): data gated (s_axis_data_tready=0, m_axis_data_tvalid=0), cfg tready=0. start_i latches fft_size into m_reg, clears err_o and goes to TAPS.
- RUN: data passes through combinationally. sample_cnt increments on each data handshake, modulo m_reg. start_i latches the new fft_size and goes to HALT. The old m_reg is still used for boundary detection.
- HALT: data keeps passing until sample_cnt==0 at a cycle with no data handshake pending, then gates and goes to TAPS. If sample_cnt is already 0 when start_i arrives, go to TAPS directly.
- TAPS: the cfg stream is routed to the reload port (tvalid/tdata/tlast forward, tready backward, zero latency). word_cnt counts handshakes. Expected length is m_reg*TAPS_PER_PHASE.
- MASK: same routing, to the select port. Expected length is m_reg/32 (one bit per channel).
- Length check, per block:
  - A handshake with tlast at word_cnt==expected-1 advances TAPS→MASK or MASK→RUN. Advancing clears word_cnt and sample_cnt and pulses done_o on RUN entry.
  - tlast earlier than expected sets err_o and goes to IDLE.
  - The expected final word arriving without tlast sets err_o and goes to FLUSH.
- FLUSH: cfg tready=1, nothing forwarded, words discarded until the tlast handshake, then IDLE.
- start_i outside IDLE/RUN is ignored.
- Reset mid-operation forces IDLE and clears all counters. Downstream sees tvalid drop asynchronously. The host must resend the full configuration.

## Timing
- Reset values: all tvalid/tready outputs 0, busy_o=0, done_o=0, err_o=0, state IDLE.
- Config and data paths have zero latency and no registers; routing muxes depend only on registered state.
- State transitions take effect the cycle after the qualifying handshake or start_i.
- Throughput is one word per cycle in TAPS, MASK and RUN when downstream tready=1.
- An M=2048 reconfiguration takes at least 65536+64 cycles plus the HALT drain, which is at most m_reg-1 samples.
- AXI rule: tvalid is never dependent on tready. A word accepted upstream is always forwarded in the same cycle.

## Structure
- chan_cfg_pkg holds:
  - state enum
  - MASK_BITS_PER_WORD=32
  - function exp_len(state, m) returning expected word count
- One sub-module is natural: axis_route1to2, a combinational cfg demux with a select input and a drop enable for FLUSH.

## Test plan
- Reset, then start_i with fft_size=2048, 65536 tap words (tlast on the last), then 64 mask words -> done_o pulses once, busy_o falls, data flows, err_o=0.
- In RUN with M=512, assert start_i after 700 samples -> 324 more samples pass, then gating. The reload port sees its first word only after sample 1024.
- Taps block with tlast on word 100 (M=32, expected 1024) -> err_o=1, state IDLE, mask port never valid, data gated.
- Mask block of 3 words without tlast (M=64, expected 2) -> err_o=1, the third word is discarded in FLUSH, IDLE after tlast, the select port sees 2 words only.
- Random tready/tvalid throttling on every port (like the 50/100 ns flow_ctrl pattern) over a full M=2048 config -> word counts exact and no data handshake during TAPS/MASK.
- Assert reset_n low in the middle of TAPS -> all outputs 0 immediately. A subsequent full reconfiguration succeeds.
